// File: rtl/ram_dma.sv
// Byte-stream DMA engine in front of a single-port RAM: load mode writes a valid/ready
// stream into consecutive addresses, dump mode reads consecutive addresses back out as a stream.
module ram_dma #(
    parameter int ADDR_BITS = 13,
    parameter int WIDTH     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 mode,
    input  logic [ADDR_BITS-1:0] base,
    input  logic [ADDR_BITS:0]   len,
    output logic                 busy,
    output logic                 done,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 ram_we,
    output logic [ADDR_BITS-1:0] ram_addr,
    output logic [WIDTH-1:0]     ram_di,
    input  logic [WIDTH-1:0]     ram_do
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_DUMP_RD  = 3'd2,
        S_DUMP_CAP = 3'd3,
        S_DUMP_HS  = 3'd4,
        S_DONE     = 3'd5
    } state_e;

    localparam logic [ADDR_BITS-1:0] PTR_ONE  = {{(ADDR_BITS-1){1'b0}}, 1'b1};
    localparam logic [ADDR_BITS:0]   CNT_ONE  = {{ADDR_BITS{1'b0}}, 1'b1};
    localparam logic [ADDR_BITS:0]   CNT_ZERO = {(ADDR_BITS+1){1'b0}};

    state_e                 state_q, state_d;
    logic [ADDR_BITS-1:0]   ptr_q, ptr_d;
    logic [ADDR_BITS:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]       out_data_q, out_data_d;

    // Next-state, address/count bookkeeping and output-byte capture.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ptr_d = base;
                    cnt_d = len;
                    if (len == CNT_ZERO) begin
                        state_d = S_DONE;
                    end else if (mode) begin
                        state_d = S_DUMP_RD;
                    end else begin
                        state_d = S_LOAD;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    ptr_d   = ptr_q + PTR_ONE;
                    cnt_d   = cnt_q - CNT_ONE;
                    state_d = (cnt_q == CNT_ONE) ? S_DONE : S_LOAD;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_DUMP_RD: begin
                state_d = S_DUMP_CAP;
            end
            S_DUMP_CAP: begin
                // ram_do now reflects the address presented during DUMP_RD.
                out_data_d = ram_do;
                state_d    = S_DUMP_HS;
            end
            S_DUMP_HS: begin
                if (out_ready) begin
                    ptr_d   = ptr_q + PTR_ONE;
                    cnt_d   = cnt_q - CNT_ONE;
                    state_d = (cnt_q == CNT_ONE) ? S_DONE : S_DUMP_RD;
                end else begin
                    state_d = S_DUMP_HS;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ptr_q      <= {ADDR_BITS{1'b0}};
            cnt_q      <= CNT_ZERO;
            out_data_q <= {WIDTH{1'b0}};
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
        end
    end

    // Status, stream and RAM-port outputs decoded from the registered state.
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        ram_we    = 1'b0;
        ram_di    = {WIDTH{1'b0}};
        case (state_q)
            S_LOAD: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                ram_we   = in_valid;
                ram_di   = in_data;
            end
            S_DUMP_RD, S_DUMP_CAP: begin
                busy = 1'b1;
            end
            S_DUMP_HS: begin
                busy      = 1'b1;
                out_valid = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign ram_addr = ptr_q;
    assign out_data = out_data_q;

endmodule

// File: tb/tb_ram_dma.sv
// Directed self-checking bench for ram_dma with a behavioural write-first single-port RAM.
module tb_ram_dma;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        mode;
    logic [12:0] base;
    logic [13:0] len;
    logic        busy;
    logic        done;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        ram_we;
    logic [12:0] ram_addr;
    logic [7:0]  ram_di;
    logic [7:0]  ram_do;

    logic [7:0]  mem [0:8191];
    int          wr_count;
    int          errors;
    int          checks;

    ram_dma #(.ADDR_BITS(13), .WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .base(base), .len(len),
        .busy(busy), .done(done), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di), .ram_do(ram_do)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write-first single-port RAM model.
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_di;
            ram_do        <= ram_di;
            wr_count      <= wr_count + 1;
        end else begin
            ram_do <= mem[ram_addr];
        end
    end

    function automatic logic [7:0] pat(input int i);
        logic [7:0] a;
        logic [7:0] b;
        a = 8'((i * 37) + 5);
        b = 8'(i >> 8);
        return a ^ b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic m, input logic [12:0] b, input logic [13:0] l);
        start = 1'b1;
        mode  = m;
        base  = b;
        len   = l;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (ram_we !== 1'b0)    begin errors++; $display("FAIL reset_ram_we: got %b expected 0", ram_we); end
        checks++; if (ram_addr !== 13'h0) begin errors++; $display("FAIL reset_ram_addr: got %h expected 0000", ram_addr); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_load_wrap();
        logic [7:0]  exp_d [4];
        logic [12:0] exp_a;
        int          idx;
        int          cyc;
        int          w0;
        logic        gap;
        exp_d = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        w0 = wr_count;
        do_start(1'b0, 13'h1FFE, 14'd4);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL load_busy_rise: got %b expected 1", busy); end
        idx = 0;
        cyc = 0;
        while (idx < 4 && cyc < 20) begin
            gap      = (cyc == 1) || (cyc == 4);
            in_valid = !gap;
            in_data  = gap ? 8'hEE : exp_d[idx];
            exp_a    = 13'h1FFE + 13'(idx);
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL load_in_ready: got %b expected 1", in_ready); end
            checks++; if (ram_we !== in_valid) begin errors++; $display("FAIL load_ram_we: got %b expected %b", ram_we, in_valid); end
            checks++; if (ram_addr !== exp_a) begin errors++; $display("FAIL load_ram_addr: got %h expected %h", ram_addr, exp_a); end
            tick();
            if (!gap) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        checks++; if (idx !== 4) begin errors++; $display("FAIL load_timeout: got %0d bytes expected 4", idx); end
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL load_done: got done=%b busy=%b expected done=1 busy=0", done, busy); end
        tick();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL load_done_pulse: got done=%b busy=%b expected 0 0", done, busy); end
        checks++; if (mem[13'h1FFE] !== 8'hA1) begin errors++; $display("FAIL load_mem_1ffe: got %h expected a1", mem[13'h1FFE]); end
        checks++; if (mem[13'h1FFF] !== 8'hB2) begin errors++; $display("FAIL load_mem_1fff: got %h expected b2", mem[13'h1FFF]); end
        checks++; if (mem[13'h0000] !== 8'hC3) begin errors++; $display("FAIL load_mem_0000: got %h expected c3", mem[13'h0000]); end
        checks++; if (mem[13'h0001] !== 8'hD4) begin errors++; $display("FAIL load_mem_0001: got %h expected d4", mem[13'h0001]); end
        checks++; if (wr_count - w0 !== 4) begin errors++; $display("FAIL load_writes: got %0d expected 4", wr_count - w0); end
    endtask

    task automatic test_dump_stall();
        logic [7:0] exp_d [4];
        int         idx;
        int         cyc;
        int         first_v;
        exp_d = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        do_start(1'b1, 13'h1FFE, 14'd4);
        idx = 0;
        cyc = 0;
        first_v = -1;
        while (idx < 4 && cyc < 40) begin
            out_ready = (cyc % 3 == 0);
            #1;
            if (out_valid === 1'b1) begin
                if (first_v < 0) first_v = cyc;
                checks++; if (out_data !== exp_d[idx]) begin errors++; $display("FAIL dump_data[%0d]: got %h expected %h", idx, out_data, exp_d[idx]); end
            end
            checks++; if (ram_addr !== 13'h1FFE + 13'(idx)) begin errors++; $display("FAIL dump_addr: got %h expected %h", ram_addr, 13'h1FFE + 13'(idx)); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL dump_busy: got %b expected 1", busy); end
            if (out_valid === 1'b1 && out_ready) idx++;
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        checks++; if (idx !== 4) begin errors++; $display("FAIL dump_timeout: got %0d bytes expected 4", idx); end
        checks++; if (first_v !== 2) begin errors++; $display("FAIL dump_first_valid: got cycle %0d expected 2", first_v); end
        checks++; if (done !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL dump_done: got done=%b out_valid=%b expected 1 0", done, out_valid); end
        tick();
    endtask

    task automatic test_zero_len();
        int w0;
        for (int m = 0; m < 2; m++) begin
            w0 = wr_count;
            in_valid  = 1'b1;
            out_ready = 1'b1;
            do_start(m[0], 13'h0005, 14'd0);
            checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL zero_done[%0d]: got done=%b busy=%b expected 1 0", m, done, busy); end
            checks++; if (ram_we !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL zero_quiet[%0d]: got we=%b ov=%b expected 0 0", m, ram_we, out_valid); end
            tick();
            checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL zero_after[%0d]: got done=%b busy=%b expected 0 0", m, done, busy); end
            in_valid  = 1'b0;
            out_ready = 1'b0;
            checks++; if (wr_count - w0 !== 0) begin errors++; $display("FAIL zero_writes[%0d]: got %0d expected 0", m, wr_count - w0); end
        end
    endtask

    task automatic test_ignored_start();
        int w0;
        w0 = wr_count;
        do_start(1'b0, 13'h0100, 14'd3);
        start = 1'b1; mode = 1'b1; base = 13'h0000; len = 14'd7;
        in_valid = 1'b1;
        in_data = 8'h11; tick();
        in_data = 8'h22; tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ign_busy: got %b expected 1", busy); end
        in_data = 8'h33; tick();
        checks++; if (done !== 1'b1 || ram_we !== 1'b0) begin errors++; $display("FAIL ign_done: got done=%b we=%b expected 1 0", done, ram_we); end
        mode = 1'b0; base = 13'h0200; len = 14'd2;
        tick();
        start = 1'b0;
        in_valid = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL ign_idle: got busy=%b done=%b rdy=%b expected 0 0 0", busy, done, in_ready); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_no_restart: got busy=%b expected 0", busy); end
        checks++; if (wr_count - w0 !== 3) begin errors++; $display("FAIL ign_writes: got %0d expected 3", wr_count - w0); end
        checks++; if (mem[13'h0102] !== 8'h33) begin errors++; $display("FAIL ign_mem_0102: got %h expected 33", mem[13'h0102]); end
    endtask

    task automatic test_reset_mid_load();
        int w0;
        int ndone;
        w0 = wr_count;
        do_start(1'b0, 13'h0300, 14'd5);
        in_valid = 1'b1;
        in_data = 8'h51; tick();
        in_data = 8'h52; tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        checks++; if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_status: got busy=%b done=%b rdy=%b ov=%b expected all 0", busy, done, in_ready, out_valid); end
        checks++; if (ram_we !== 1'b0 || ram_addr !== 13'h0 || ram_di !== 8'h00) begin errors++; $display("FAIL rst_mid_ram: got we=%b addr=%h di=%h expected 0 0000 00", ram_we, ram_addr, ram_di); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rst_mid_out_data: got %h expected 00", out_data); end
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (done === 1'b1) ndone++;
        end
        checks++; if (ndone !== 0) begin errors++; $display("FAIL rst_mid_no_done: got %0d pulses expected 0", ndone); end
        checks++; if (wr_count - w0 !== 2) begin errors++; $display("FAIL rst_mid_writes: got %0d expected 2", wr_count - w0); end
        checks++; if (mem[13'h0301] !== 8'h52) begin errors++; $display("FAIL rst_mid_mem_0301: got %h expected 52", mem[13'h0301]); end
    endtask

    task automatic test_back_to_back();
        int w0;
        int nwe;
        int bad;
        w0 = wr_count;
        nwe = 0;
        do_start(1'b0, 13'h0000, 14'd8192);
        in_valid = 1'b1;
        for (int c = 0; c < 8192; c++) begin
            in_data = pat(c);
            #1;
            if (ram_we === 1'b1) nwe++;
            tick();
        end
        in_valid = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_load_done: got %b expected 1", done); end
        checks++; if (nwe !== 8192 || wr_count - w0 !== 8192) begin errors++; $display("FAIL b2b_writes: got we=%0d commits=%0d expected 8192", nwe, wr_count - w0); end
        tick();
        out_ready = 1'b1;
        do_start(1'b1, 13'h0000, 14'd8192);
        bad = 0;
        for (int i = 0; i < 8192; i++) begin
            if (out_valid !== 1'b0) bad++;
            tick();
            if (out_valid !== 1'b0) bad++;
            tick();
            if (out_valid !== 1'b1 || out_data !== pat(i)) bad++;
            tick();
        end
        out_ready = 1'b0;
        checks++; if (bad !== 0) begin errors++; $display("FAIL b2b_dump_stream: got %0d bad cycles expected 0", bad); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_dump_done: got %b expected 1", done); end
        tick();
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        wr_count  = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        mode      = 1'b0;
        base      = 13'h0;
        len       = 14'h0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_load_wrap();
        test_dump_stall();
        test_zero_len();
        test_ignored_start();
        test_reset_mid_load();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_dma.md
# ram_dma

Byte-stream DMA engine that sits directly upstream of the single-port `ram` block and owns its `we`/`addr`/`di` inputs and `do` output. It has two modes. In load mode it writes a valid/ready byte stream into consecutive RAM addresses. In dump mode it reads consecutive RAM addresses and presents them as a valid/ready byte stream. The host requests a transfer with a one-cycle `start`, and the block pulses `done` when the transfer is complete.

## Interface
- `ADDR_BITS`, default 13: RAM address width; must match the attached `ram` instance.
- `WIDTH`, default 8: data width in bits.

- `clk`  in  1  single clock shared with `ram`.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  one-cycle transfer request; sampled only in IDLE.
- `mode`  in  1  0 = load (stream to RAM), 1 = dump (RAM to stream); sampled with `start`.
- `base`  in  ADDR_BITS  first RAM address; sampled with `start`.
- `len`  in  ADDR_BITS+1  byte count, 0..2^(ADDR_BITS+1)-1; sampled with `start`.
- `busy`  out  1  high while in LOAD or any DUMP state.
- `done`  out  1  one-cycle pulse after the final byte of a transfer.
- `in_data`  in  WIDTH  load-stream byte.
- `in_valid`  in  1  load-stream valid.
- `in_ready`  out  1  load-stream ready.
- `out_data`  out  WIDTH  dump-stream byte, registered.
- `out_valid`  out  1  dump-stream valid.
- `out_ready`  in  1  dump-stream ready.
- `ram_we`  out  1  to `ram.we`.
- `ram_addr`  out  ADDR_BITS  to `ram.addr`.
- `ram_di`  out  WIDTH  to `ram.di`.
- `ram_do`  in  WIDTH  from `ram.do`; equals `ram[addr registered on the previous edge]`.

## Operation
- **Internal registers:**
  - `ptr` (ADDR_BITS): current address. Increments modulo 2^ADDR_BITS, so 0x1FFF wraps to 0x0000.
  - `cnt` (ADDR_BITS+1): bytes remaining.
- **States:** IDLE, LOAD, DUMP_RD, DUMP_CAP, DUMP_HS, DONE.
- **IDLE:**
  - On `start`=1, load `ptr`=`base` and `cnt`=`len`.
  - If `len`=0, go to DONE.
  - Otherwise go to LOAD if `mode`=0, or DUMP_RD if `mode`=1.
- **LOAD:**
  - `in_ready`=1.
  - `ram_we` = `in_valid`; `ram_addr`=`ptr`; `ram_di`=`in_data`. These three outputs are combinational.
  - On each accepted handshake, `ptr`++ and `cnt`--.
  - If `cnt`=1 at the handshake, go to DONE.
- **DUMP_RD:** `ram_addr`=`ptr`. Go to DUMP_CAP.
- **DUMP_CAP:**
  - `ram_addr` is held at `ptr`.
  - `out_data` <= `ram_do`.
  - Go to DUMP_HS.
- **DUMP_HS:**
  - `out_valid`=1, and `out_data` is held stable until the handshake.
  - On `out_ready`, `ptr`++ and `cnt`--. Go to DONE if `cnt`=1, else go to DUMP_RD.
- **DONE:** `done`=1 and `busy`=0 for one cycle, then go to IDLE.
- **Signals outside their owning state:**
  - `ram_we`=0 in every state except LOAD.
  - `ram_addr`=`ptr` in every state.
  - `in_ready`=0 outside LOAD.
  - `out_valid`=0 outside DUMP_HS.
- **`start` outside IDLE** (including during DONE) is ignored. Inputs are not queued.
- **`len` > 2^ADDR_BITS** is legal: addresses wrap, and later bytes overwrite or re-read earlier ones.
- **Reset** (`rst_n`=0 at a clock edge), from any state including mid-transfer:
  - `state`=IDLE, `ptr`=0, `cnt`=0, `out_data`=0.
  - `busy`=0, `done`=0, `in_ready`=0, `out_valid`=0, `ram_we`=0, `ram_addr`=0, `ram_di`=0.
  - No `done` pulse is generated for the aborted transfer.

## Timing
- **`start` latency:** `start` at edge N puts the block in LOAD, DUMP_RD or DONE in cycle N+1. `busy` rises in cycle N+1, except when `len`=0.
- **Load throughput:** 1 byte per cycle. The RAM write commits on the same edge as the handshake.
- **Dump latency:** 3 cycles per byte with `out_ready` held high:
  - RD presents the address, which `ram` registers at the end of the cycle.
  - CAP reads `ram_do`, now `ram[ptr]`, and registers it.
  - HS completes the handshake.
  - A stall in HS extends only HS.
- **`done` latency:** `done` rises in the cycle after the final handshake. For `len`=0, `done` appears at N+1 with `busy` staying 0.
- **Contention:** no write/read hazard exists. Load and dump never overlap, and `ram` returns new data on a write.

## Test plan
- **Load with wrap:** load, `base`=0x1FFE, `len`=4, bytes A1,B2,C3,D4 with `in_valid` gaps → `ram[0x1FFE]`=A1, `[0x1FFF]`=B2, `[0x0000]`=C3, `[0x0001]`=D4; one `done` pulse, then `busy`=0.
- **Dump with stalls:** dump the same range with `out_ready` toggling 1,0,0,1… → stream A1,B2,C3,D4 in order; `out_data` held stable during stalls; `out_valid` never high outside a pending byte.
- **Zero length:** `len`=0 in either mode → `done` at N+1; no `ram_we`; no `out_valid`; `busy` never high.
- **Ignored `start`:** `start` pulsed while busy and while in DONE → ignored; the original transfer completes with the original count.
- **Reset mid-load:** `rst_n`=0 after 2 of 5 bytes → next cycle all outputs at reset values, no `done`; only the first 2 bytes were written.
- **Back-to-back full transfers:** load 8192 bytes with `in_valid` held high, then dump them → exactly 8192 writes in 8192 cycles; dump returns identical data at 3 cycles per byte.
